collision_detector: RTL and testbench
=====================================

Name: collision_detector

Overview:
- Consumes the per-pixel drawing-request outputs of the on-screen objects, e.g. player, rope and balls.
- Counts the pixels where an object of group A and an object of group B are both drawn during one VGA frame.
- At each start-of-frame it publishes the collisions found in the previous frame: per-pair and per-object hit flags plus a one-cycle valid pulse.
- Sits between the object blocks and the game-logic controllers, alongside the objects mux.

Parameters:
- NUM_A, 2, number of group-A objects (player, rope).
- NUM_B, 4, number of group-B objects (balls).
- MIN_OVERLAP, 4, overlapping pixels per frame needed to declare a pair hit; range 1..2^COUNT_W-1.
- COUNT_W, 8, width of each per-pair saturating overlap counter.

Ports:
- clk  in  1  system clock (pixel clock domain).
- reset  in  1  asynchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse from the VGA controller at the first pixel of a frame.
- enable  in  1  when 0, overlaps are not counted (game paused or over).
- drawReqA  in  NUM_A  drawing requests of group A, bit i = object i; cycle-aligned with drawReqB.
- drawReqB  in  NUM_B  drawing requests of group B.
- hitPair  out  NUM_A*NUM_B  bit i*NUM_B+j = pair (A i, B j) hit in the last completed frame.
- hitA  out  NUM_A  bit i = OR over j of hitPair(i,j).
- hitB  out  NUM_B  bit j = OR over i of hitPair(i,j).
- frameDone  out  1  one-cycle pulse when hitPair/hitA/hitB update.
- anyHit  out  1  OR of all hitPair bits.

Behaviour:
- Reset, asynchronous while reset=1:
  - all counters = 0; hitPair, hitA, hitB, anyHit and frameDone = 0.
  - Deasserting reset mid-frame starts counting from 0.
  - The first frameDone after reset reflects only the partial frame.
- Overlap(i,j) in a cycle = drawReqA[i] & drawReqB[j] & enable.
- Counter(i,j), on a cycle without startOfFrame:
  - increments by 1 when Overlap(i,j)=1.
  - saturates at 2^COUNT_W-1 and never wraps.
- Cycle with startOfFrame=1, evaluated at posedge t:
  - hitPair(i,j) <= (Counter(i,j) >= MIN_OVERLAP), using the counter value before this edge.
  - hitA, hitB and anyHit are registered at the same edge from the same comparison results, so all four outputs change together.
  - frameDone <= 1 for exactly one cycle, high during cycle t+1, low otherwise.
  - Counter(i,j) <= Overlap(i,j) of the same cycle: a pixel coinciding with startOfFrame counts toward the new frame and is not lost.
- Outputs hold their values for the whole following frame; they are level signals, not pulses.
- Latency: last overlap pixel of frame N to visible hitPair is at most the remainder of frame N plus 1 cycle.
- Back-to-back startOfFrame pulses: each one evaluates and clears; an empty interval gives hitPair = 0 with frameDone still pulsed.
- Overlaps within group A or within group B are ignored.
- enable=0 freezes the counters but does not block evaluation: startOfFrame still publishes the current counts and clears them.
- No state machine beyond counters plus output registers; the frame boundary is the only event.
- Width rule: comparison is unsigned against MIN_OVERLAP zero-extended to COUNT_W.

Test Plan:
- Reset, then no draw requests for 2 frames -> hitPair=0, anyHit=0, frameDone pulses once per startOfFrame, 1 cycle wide.
- A0 and B2 overlap for 4 consecutive cycles in frame 1 -> at the following startOfFrame: hitPair bit 2 = 1, hitA=2'b01, hitB=4'b0100, anyHit=1; these hold through frame 2 and clear after frame 2 if no overlap.
- A1 and B3 overlap for 3 cycles (below MIN_OVERLAP=4) -> hitPair=0, hitA=0 after the frame boundary.
- Overlap of A0 and B0 asserted exactly in the startOfFrame cycle plus 3 more cycles -> the next frameDone reports hitPair bit 0 = 1; the boundary pixel counts toward the new frame.
- 300 overlapping cycles with COUNT_W=8 -> counter saturates at 255, no wrap, hitPair bit = 1; with enable=0 for the same stimulus -> hitPair=0.
- Assert reset mid-frame after 10 overlap cycles -> all outputs 0 immediately; the next frameDone reports only overlaps counted after reset release.

Source files
------------

// File: rtl/collision_detector.sv
`default_nettype none
// ============================================================================
//  Module      : collision_detector
//  Description : Counts per-frame pixel overlaps between every (group A,
//                group B) object pair and, at each start-of-frame, publishes
//                the pairs whose overlap reached MIN_OVERLAP in the frame
//                that just ended.
//  Revision    : 1.0 - initial release
// ============================================================================
module collision_detector #(
    parameter int NUM_A       = 2,
    parameter int NUM_B       = 4,
    parameter int MIN_OVERLAP = 4,
    parameter int COUNT_W     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   startOfFrame,
    input  logic                   enable,
    input  logic [NUM_A-1:0]       drawReqA,
    input  logic [NUM_B-1:0]       drawReqB,
    output logic [NUM_A*NUM_B-1:0] hitPair,
    output logic [NUM_A-1:0]       hitA,
    output logic [NUM_B-1:0]       hitB,
    output logic                   frameDone,
    output logic                   anyHit
);

    localparam int                 C_NUM_P = NUM_A * NUM_B;
    localparam logic [COUNT_W-1:0] C_MIN   = COUNT_W'(MIN_OVERLAP);
    localparam logic [COUNT_W-1:0] C_MAX   = {COUNT_W{1'b1}};

    logic [C_NUM_P-1:0]              w_overlap;
    logic [C_NUM_P-1:0]              w_hit;
    logic [NUM_A-1:0]                w_hit_a;
    logic [NUM_B-1:0]                w_hit_b;
    logic [C_NUM_P-1:0][COUNT_W-1:0] r_count;

    // Pair (i,j) overlaps when both objects draw the same pixel while enabled
    for (genvar gi = 0; gi < NUM_A; gi++) begin : g_row
        for (genvar gj = 0; gj < NUM_B; gj++) begin : g_col
            assign w_overlap[gi*NUM_B+gj] = drawReqA[gi] & drawReqB[gj] & enable;
        end
    end

    // Hit decision and its per-object reductions, from the pre-edge counts
    always_comb begin
        w_hit   = '0;
        w_hit_a = '0;
        w_hit_b = '0;
        for (int i = 0; i < NUM_A; i++) begin
            for (int j = 0; j < NUM_B; j++) begin
                w_hit[i*NUM_B+j] = (r_count[i*NUM_B+j] >= C_MIN);
                w_hit_a[i]       = w_hit_a[i] | w_hit[i*NUM_B+j];
                w_hit_b[j]       = w_hit_b[j] | w_hit[i*NUM_B+j];
            end
        end
    end

    // Saturating overlap counters; a frame start reloads with the boundary pixel
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            for (int p = 0; p < C_NUM_P; p++) begin
                if (startOfFrame) begin
                    r_count[p] <= {{(COUNT_W-1){1'b0}}, w_overlap[p]};
                end else if (w_overlap[p] && (r_count[p] != C_MAX)) begin
                    r_count[p] <= r_count[p] + 1'b1;
                end
            end
        end
    end

    // Published results change together at the frame boundary and then hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hitPair   <= '0;
            hitA      <= '0;
            hitB      <= '0;
            anyHit    <= 1'b0;
            frameDone <= 1'b0;
        end else begin
            frameDone <= startOfFrame;
            if (startOfFrame) begin
                hitPair <= w_hit;
                hitA    <= w_hit_a;
                hitB    <= w_hit_b;
                anyHit  <= |w_hit;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_collision_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_collision_detector
//  Description : Self-checking bench for collision_detector: frame table,
//                hand-written corner sequences and randomized traffic against
//                a per-pair pixel-count reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_collision_detector;

    localparam int NA  = 2;
    localparam int NB  = 4;
    localparam int NP  = NA * NB;
    localparam int MIN = 4;
    localparam int SAT = 255;

    logic          clk = 1'b0;
    logic          reset;
    logic          startOfFrame;
    logic          enable;
    logic [NA-1:0] drawReqA;
    logic [NB-1:0] drawReqB;
    logic [NP-1:0] hitPair;
    logic [NA-1:0] hitA;
    logic [NB-1:0] hitB;
    logic          frameDone;
    logic          anyHit;

    collision_detector #(
        .NUM_A(NA), .NUM_B(NB), .MIN_OVERLAP(MIN), .COUNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .enable(enable),
        .drawReqA(drawReqA), .drawReqB(drawReqB), .hitPair(hitPair),
        .hitA(hitA), .hitB(hitB), .frameDone(frameDone), .anyHit(anyHit)
    );

    always #5 clk = ~clk;

    // Reference model: pixel count per pair in the current frame
    int            cnt [NP];
    logic [NP-1:0] e_pair;
    logic [NA-1:0] e_a;
    logic [NB-1:0] e_b;
    logic          e_any;
    logic          e_done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [NA-1:0] a;
        logic [NB-1:0] b;
        logic          en;
        int            len;
        logic [NP-1:0] x_pair;
        logic [NA-1:0] x_a;
        logic [NB-1:0] x_b;
    } frame_vec_t;

    frame_vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int p = 0; p < NP; p++) cnt[p] = 0;
        e_pair = '0; e_a = '0; e_b = '0; e_any = 1'b0; e_done = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".hitPair"},   32'(hitPair),   32'(e_pair));
        check({tag, ".hitA"},      32'(hitA),      32'(e_a));
        check({tag, ".hitB"},      32'(hitB),      32'(e_b));
        check({tag, ".anyHit"},    32'(anyHit),    32'(e_any));
        check({tag, ".frameDone"}, 32'(frameDone), 32'(e_done));
    endtask

    // One pixel clock: drive, advance model at the edge, compare 1 ns later
    task automatic cyc(input logic sof, input logic en,
                       input logic [NA-1:0] a, input logic [NB-1:0] b);
        logic ov;
        startOfFrame = sof; enable = en; drawReqA = a; drawReqB = b;
        @(posedge clk);
        for (int p = 0; p < NP; p++) begin
            ov = a[p / NB] & b[p % NB] & en;
            if (sof) begin
                e_pair[p] = (cnt[p] >= MIN);
                cnt[p]    = ov ? 1 : 0;
            end else if (ov) begin
                cnt[p] = (cnt[p] >= SAT) ? SAT : cnt[p] + 1;
            end
        end
        e_done = sof;
        e_a = '0; e_b = '0;
        for (int p = 0; p < NP; p++) begin
            e_a[p / NB] = e_a[p / NB] | e_pair[p];
            e_b[p % NB] = e_b[p % NB] | e_pair[p];
        end
        e_any = |e_pair;
        #1;
        check_all("cyc");
    endtask

    task automatic run(input int n, input logic en, input logic [NA-1:0] a, input logic [NB-1:0] b);
        for (int k = 0; k < n; k++) cyc(1'b0, en, a, b);
    endtask

    task automatic mid_reset();
        reset = 1'b1;
        #2;
        model_clear();
        check_all("async_reset");
        #2;
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{2'b01, 4'b0100, 1'b1,  4, 8'h04, 2'b01, 4'b0100};
        vecs[1] = '{2'b10, 4'b1000, 1'b1,  3, 8'h00, 2'b00, 4'b0000};
        vecs[2] = '{2'b11, 4'b0011, 1'b1,  4, 8'h33, 2'b11, 4'b0011};
        vecs[3] = '{2'b01, 4'b0001, 1'b0, 10, 8'h00, 2'b00, 4'b0000};
        vecs[4] = '{2'b11, 4'b0000, 1'b1, 10, 8'h00, 2'b00, 4'b0000};
        vecs[5] = '{2'b10, 4'b1111, 1'b1,  5, 8'hF0, 2'b10, 4'b1111};
        vecs[6] = '{2'b00, 4'b0000, 1'b1,  0, 8'h00, 2'b00, 4'b0000};

        reset = 1'b1; startOfFrame = 1'b0; enable = 1'b1; drawReqA = '0; drawReqB = '0;
        model_clear();
        #12;
        check_all("reset");
        reset = 1'b0;

        // Two empty frames
        cyc(1'b1, 1'b1, '0, '0);
        run(10, 1'b1, '0, '0);
        cyc(1'b1, 1'b1, '0, '0);
        run(10, 1'b1, '0, '0);
        cyc(1'b1, 1'b1, '0, '0);
        check("empty.hitPair", 32'(hitPair), 32'h0);

        // Frame table: overlap burst, idle, boundary, explicit result check
        for (int v = 0; v < 7; v++) begin
            run(vecs[v].len, vecs[v].en, vecs[v].a, vecs[v].b);
            run(5, 1'b1, '0, '0);
            cyc(1'b1, 1'b1, '0, '0);
            check("tbl.hitPair",   32'(hitPair),   32'(vecs[v].x_pair));
            check("tbl.hitA",      32'(hitA),      32'(vecs[v].x_a));
            check("tbl.hitB",      32'(hitB),      32'(vecs[v].x_b));
            check("tbl.anyHit",    32'(anyHit),    32'(|vecs[v].x_pair));
            check("tbl.frameDone", 32'(frameDone), 32'h1);
            run(3, 1'b1, '0, '0);
            check("tbl.hold", 32'(hitPair), 32'(vecs[v].x_pair));
        end

        // Boundary pixel counts toward the new frame
        cyc(1'b1, 1'b1, 2'b01, 4'b0001);
        run(3, 1'b1, 2'b01, 4'b0001);
        run(4, 1'b1, '0, '0);
        cyc(1'b1, 1'b1, '0, '0);
        check("boundary.hitPair", 32'(hitPair), 32'h01);

        // Back-to-back frame starts: second one sees only the first's pixel
        run(6, 1'b1, 2'b10, 4'b0010);
        cyc(1'b1, 1'b1, 2'b10, 4'b0010);
        cyc(1'b1, 1'b1, '0, '0);
        check("b2b.hitPair", 32'(hitPair), 32'h00);
        check("b2b.frameDone", 32'(frameDone), 32'h1);

        // Saturation: 256 and 300 overlaps must not wrap
        run(256, 1'b1, 2'b01, 4'b0001);
        cyc(1'b1, 1'b1, '0, '0);
        check("sat256.hitPair", 32'(hitPair), 32'h01);
        run(300, 1'b1, 2'b01, 4'b0001);
        cyc(1'b1, 1'b1, '0, '0);
        check("sat300.hitPair", 32'(hitPair), 32'h01);
        run(300, 1'b0, 2'b01, 4'b0001);
        cyc(1'b1, 1'b1, '0, '0);
        check("disabled.hitPair", 32'(hitPair), 32'h00);

        // Mid-frame reset: outputs drop at once, pre-reset pixels forgotten
        run(4, 1'b1, 2'b01, 4'b0001);
        cyc(1'b1, 1'b1, '0, '0);
        run(10, 1'b1, 2'b01, 4'b0001);
        mid_reset();
        run(3, 1'b1, 2'b01, 4'b0001);
        cyc(1'b1, 1'b1, '0, '0);
        check("rst_partial3.hitPair", 32'(hitPair), 32'h00);
        run(10, 1'b1, 2'b01, 4'b0001);
        mid_reset();
        run(4, 1'b1, 2'b01, 4'b0001);
        cyc(1'b1, 1'b1, '0, '0);
        check("rst_partial4.hitPair", 32'(hitPair), 32'h01);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            cyc(($urandom_range(0, 11) == 0),
                ($urandom_range(0, 9) != 0),
                NA'($urandom),
                NB'($urandom & $urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety net against a stuck run
    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
